// File: rtl/nand_logic_seq.sv
// Multi-cycle 16-bit logic unit: every logic op is built from one shared NAND stage, one NAND per clock.
// Latency: N cycles from accepted start to the done pulse (N = 1..5, depending on op).
// Backpressure: start is ignored while busy. Optional macro NLS_XOR_EN enables ops 100/101; otherwise they are flagged illegal.
module nand_logic_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zero,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {D_T1, D_T2, D_R} dst_t;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, t1_q, t1_d, t2_q, t2_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  op_q, op_d, step_q, step_d;
    logic        busy_q, busy_d, done_q, done_d, zero_q, zero_d, illegal_q, illegal_d;

    logic [15:0] nx, ny, nand_out;
    dst_t        dst;
    logic        skip;

    // Operand routing for the current step. NOR/XNOR park the OR/XOR value in T1
    // and invert it on the last step, so result only ever changes on completion.
    always_comb begin
        nx   = a_q;
        ny   = b_q;
        dst  = D_R;
        skip = 1'b0;
        case (op_q)
            OP_AND: begin
                if (step_q == 3'd0) dst = D_T1;
                else begin nx = t1_q; ny = t1_q; end
            end
            OP_OR, OP_NOR: begin
                case (step_q)
                    3'd0: begin nx = a_q;  ny = a_q;  dst = D_T1; end
                    3'd1: begin nx = b_q;  ny = b_q;  dst = D_T2; end
                    3'd2: begin nx = t1_q; ny = t2_q; dst = (op_q == OP_NOR) ? D_T1 : D_R; end
                    default: begin nx = t1_q; ny = t1_q; end
                endcase
            end
            OP_XOR, OP_XNOR: begin
`ifdef NLS_XOR_EN
                case (step_q)
                    3'd0: dst = D_T1;
                    3'd1: begin nx = a_q;  ny = t1_q; dst = D_T2; end
                    3'd2: begin nx = b_q;  ny = t1_q; dst = D_T1; end
                    3'd3: begin nx = t2_q; ny = t1_q; dst = (op_q == OP_XNOR) ? D_T1 : D_R; end
                    default: begin nx = t1_q; ny = t1_q; end
                endcase
`else
                skip = 1'b1;
`endif
            end
            OP_NOT: ny = a_q;
            OP_PASS: begin
                if (step_q == 3'd0) begin nx = a_q; ny = a_q; dst = D_T1; end
                else begin nx = t1_q; ny = t1_q; end
            end
            default: ;
        endcase
        nand_out = ~(nx & ny);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        step_d    = step_q;
        result_d  = result_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    step_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                step_d = step_q + 3'd1;
                if (skip) begin
                    result_d  = 16'h0000;
                    zero_d    = 1'b1;
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    case (dst)
                        D_T1: t1_d = nand_out;
                        D_T2: t2_d = nand_out;
                        default: begin
                            result_d = nand_out;
                            zero_d   = (nand_out == 16'h0000);
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            op_q      <= 3'd0;
            t1_q      <= 16'h0000;
            t2_q      <= 16'h0000;
            step_q    <= 3'd0;
            result_q  <= 16'h0000;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            step_q    <= step_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_nand_logic_seq.sv
// Directed bench for nand_logic_seq: a behavioural model fills a scoreboard at each start, entries are checked at done.
module tb_nand_logic_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, zero, illegal;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic        z;
        int          lat;
        logic        ill;
        int          t0;
        string       tag;
    } exp_t;
    exp_t sbq[$];

    nand_logic_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef NLS_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e.ill = 1'b0;
        case (o)
            3'd0: begin e.res = ~(x & y); e.lat = 1; end
            3'd1: begin e.res = x & y;    e.lat = 2; end
            3'd2: begin e.res = x | y;    e.lat = 3; end
            3'd3: begin e.res = ~(x | y); e.lat = 4; end
            3'd4: begin e.res = x ^ y;    e.lat = 4; end
            3'd5: begin e.res = ~(x ^ y); e.lat = 5; end
            3'd6: begin e.res = ~x;       e.lat = 1; end
            default: begin e.res = x;     e.lat = 2; end
        endcase
        if (!XOR_EN && (o == 3'd4 || o == 3'd5)) begin
            e.res = 16'h0000;
            e.lat = 1;
            e.ill = 1'b1;
        end
        e.z = (e.res == 16'h0000);
        e.t0 = 0;
        e.tag = "";
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; drives start for one cycle and records the expectation.
    task automatic issue(input string tag, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        e = model(o, x, y);
        e.t0 = cyc;
        e.tag = tag;
        sbq.push_back(e);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_check();
        exp_t e;
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        chk({e.tag, "_done"}, done, 1);
        chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
        chk({e.tag, "_res"}, result, e.res);
        chk({e.tag, "_zero"}, zero, e.z);
        chk({e.tag, "_ill"}, illegal, e.ill);
        chk({e.tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        logic [2:0] xor_op;
        logic [2:0] xnor_op;
        xor_op  = XOR_EN ? 3'd4 : 3'd3;
        xnor_op = XOR_EN ? 3'd5 : 3'd3;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_res", result, 16'h0000);
        chk("rst_zero", zero, 1);
        reset = 1'b0;
        @(negedge clk);

        // Every op on the reference operands, each followed by an idle cycle.
        for (int i = 0; i < 8; i++) begin
            issue($sformatf("op%0d", i), 3'(i), 16'hF0F0, 16'hFF00);
            wait_check();
            @(negedge clk);
            chk($sformatf("op%0d_pulse", i), done, 0);
        end

        issue("and_zero", 3'd1, 16'h00FF, 16'hFF00);
        wait_check();
        @(negedge clk);
        chk("and_zero_pulse", done, 0);
        chk("and_zero_hold", result, 16'h0000);

        // Start during EXEC must be ignored; start in the done cycle runs back-to-back.
        issue("b2b_first", xor_op, 16'hF0F0, 16'hFF00);
        start = 1'b1; op = 3'd0; a = 16'h0000; b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        wait_check();
        issue("b2b_second", 3'd0, 16'hFFFF, 16'hFFFF);
        wait_check();
        @(negedge clk);

        issue("pre_rst_not", 3'd6, 16'h0000, 16'h0000);
        wait_check();
        @(negedge clk);

        // Reset in the third EXEC cycle abandons the op without a done pulse.
        issue("abandon", xnor_op, 16'hF0F0, 16'hFF00);
        void'(sbq.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_res", result, 16'h0000);
        chk("mid_rst_zero", zero, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_nodone", done, 0);
        end
        issue("post_rst_nand", 3'd0, 16'h0000, 16'h0000);
        wait_check();
        @(negedge clk);

        issue("xor_1234", 3'd4, 16'h1234, 16'h0000);
        wait_check();
        issue("or_after", 3'd2, 16'h1200, 16'h0034);
        wait_check();
        @(negedge clk);
        chk("final_pulse", done, 0);
        chk("final_sbq_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
